// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_timer_unit register bank:
//   - rd_sel read-source encoding (codes 6 and 7 are unused and read as zero)
//   - offsets of the stack-pointer (SP) and auxiliary-stack (AS) registers,
//     counted down from the top of the general register file
//   - state encoding for the delay controller inside the tick timer
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic [2:0] {
        RD_NONE  = 3'd0,
        RD_REG   = 3'd1,
        RD_HI    = 3'd2,
        RD_LO    = 3'd3,
        RD_TIME  = 3'd4,
        RD_PTIME = 3'd5
    } rd_sel_e;

    // SP lives in reg[REG_COUNT-1], AS in reg[REG_COUNT-2].
    localparam int SP_FROM_TOP = 1;
    localparam int AS_FROM_TOP = 2;

    typedef enum logic {
        DLY_IDLE = 1'b0,
        DLY_BUSY = 1'b1
    } delay_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_timer_unit_if.sv
// -----------------------------------------------------------------------------
// regfile_timer_unit_if
// Decode-side bus of the register bank. The master modport is the decode
// stage (drives reads, writes, stack and timer controls); the slave modport is
// the register bank itself.
//   rd_sel/rd_addr0/rd_addr1 -> rd_data0/rd_data1   registered read port
//   wr_en/wr_addr/wr_data                           general register write
//   hilo_we/hi_in/lo_in                             HI/LO load
//   ptime_we                                        PTIME load from wr_data
//   cmp_we/cmp_in -> cmp_flag                       compare flag
//   sp_push/sp_pop/as_push/as_pop -> sp_out/as_out  hardware stacks
//   delay_start -> delay_busy, time_out             timer and delay
//   stk_ovf/stk_unf                                 sticky stack error flags
// -----------------------------------------------------------------------------
interface regfile_timer_unit_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    logic [2:0]        rd_sel;
    logic [AW-1:0]     rd_addr0;
    logic [AW-1:0]     rd_addr1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              hilo_we;
    logic [DATA_W-1:0] hi_in;
    logic [DATA_W-1:0] lo_in;
    logic              ptime_we;
    logic              cmp_we;
    logic              cmp_in;
    logic              cmp_flag;
    logic              sp_push;
    logic              sp_pop;
    logic              as_push;
    logic              as_pop;
    logic [DATA_W-1:0] sp_out;
    logic [DATA_W-1:0] as_out;
    logic              delay_start;
    logic              delay_busy;
    logic [DATA_W-1:0] time_out;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output rd_sel, rd_addr0, rd_addr1, wr_en, wr_addr, wr_data,
               hilo_we, hi_in, lo_in, ptime_we, cmp_we, cmp_in,
               sp_push, sp_pop, as_push, as_pop, delay_start,
        input  rd_data0, rd_data1, cmp_flag, sp_out, as_out,
               delay_busy, time_out, stk_ovf, stk_unf
    );

    modport slave (
        input  rd_sel, rd_addr0, rd_addr1, wr_en, wr_addr, wr_data,
               hilo_we, hi_in, lo_in, ptime_we, cmp_we, cmp_in,
               sp_push, sp_pop, as_push, as_pop, delay_start,
        output rd_data0, rd_data1, cmp_flag, sp_out, as_out,
               delay_busy, time_out, stk_ovf, stk_unf
    );

endinterface : regfile_timer_unit_if

// File: rtl/regfile_tick_timer.sv
// -----------------------------------------------------------------------------
// regfile_tick_timer
// Prescaled free-running TIME counter plus a one-shot delay with a deadline.
//   clk, reset    clock (rising edge), asynchronous active-low reset
//   ptime         current PTIME value (delay length in ticks)
//   delay_start   arm the delay: deadline = TIME + PTIME
//   time_out      current TIME
//   delay_busy    high from the cycle after arming until TIME reaches deadline
// -----------------------------------------------------------------------------
module regfile_tick_timer
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ptime,
    input  logic              delay_start,
    output logic [DATA_W-1:0] time_out,
    output logic              delay_busy
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [DATA_W-1:0] time_q, time_d;
    logic [DATA_W-1:0] deadline_q, deadline_d;
    delay_state_e      state_q, state_d;
    logic              presc_tc;

    // NOTE: state registers use non-blocking assignments only; blocking here
    // would create order-dependent simulation races with other flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            time_q     <= '0;
            deadline_q <= '0;
            state_q    <= DLY_IDLE;
        end else begin
            presc_q    <= presc_d;
            time_q     <= time_d;
            deadline_q <= deadline_d;
            state_q    <= state_d;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        presc_tc   = (presc_q == PRESC_LAST);
        presc_d    = presc_tc ? '0 : presc_q + 1'b1;
        time_d     = time_q + DATA_W'(presc_tc);
        state_d    = state_q;
        deadline_d = deadline_q;

        case (state_q)
            DLY_IDLE: begin
                if (delay_start && (ptime != '0)) begin
                    deadline_d = time_q + ptime;
                    state_d    = DLY_BUSY;
                end
            end
            DLY_BUSY: begin
                // Re-arming restarts from the current TIME; a zero-length
                // re-arm simply ends the delay.
                if (delay_start) begin
                    if (ptime != '0) begin
                        deadline_d = time_q + ptime;
                    end else begin
                        state_d = DLY_IDLE;
                    end
                end else if (time_q == deadline_q) begin
                    // Equality rather than magnitude keeps this wrap-safe.
                    state_d = DLY_IDLE;
                end
            end
            default: state_d = DLY_IDLE;
        endcase
    end

    assign time_out   = time_q;
    assign delay_busy = (state_q == DLY_BUSY);

endmodule : regfile_tick_timer

// File: rtl/regfile_timer_unit.sv
// -----------------------------------------------------------------------------
// regfile_timer_unit
// Register bank between decode and execute: general register file with a
// hardwired zero register, HI/LO pair, SP/AS hardware stacks held in the top
// two registers, compare flag, and a prescaled timer with a delay deadline.
//   clk, reset  clock (rising edge), asynchronous active-low reset
//   bus         regfile_timer_unit_if.slave (reads, writes, stacks, timer)
// Build option: define REGFILE_STACK_CHECK_EN to suppress out-of-range SP/AS
// operations and raise the sticky stk_ovf/stk_unf flags; without it the
// counters wrap and both flags are tied low.
// -----------------------------------------------------------------------------
module regfile_timer_unit
    import regfile_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                REG_COUNT = 32,
    parameter logic [DATA_W-1:0] SP_STEP   = 4,
    parameter logic [DATA_W-1:0] SP_TOP    = 'h400,
    parameter logic [DATA_W-1:0] SP_FLOOR  = 'h0,
    parameter int                PRESCALE  = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_timer_unit_if.slave  bus
);

    localparam int            AW      = $clog2(REG_COUNT);
    localparam int            SP_IDX  = REG_COUNT - SP_FROM_TOP;
    localparam int            AS_IDX  = REG_COUNT - AS_FROM_TOP;
    localparam logic [AW-1:0] SP_ADDR = AW'(SP_IDX);
    localparam logic [AW-1:0] AS_ADDR = AW'(AS_IDX);

    if (SP_FLOOR > SP_TOP) begin : g_bad_stack_range
        $error("regfile_timer_unit: SP_FLOOR must not exceed SP_TOP");
    end

    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] ptime_q, ptime_d;
    logic [DATA_W-1:0] rd_data0_q, rd_data0_d, rd_data1_q, rd_data1_d;
    logic              cmp_flag_q, cmp_flag_d;
    logic [DATA_W-1:0] sp_cur, as_cur, time_val;
    logic              sp_wr_hit, as_wr_hit, byp0, byp1;

`ifdef REGFILE_STACK_CHECK_EN
    logic              stk_ovf_q, stk_ovf_d, stk_unf_q, stk_unf_d;
    // One extra bit so the range tests cannot be fooled by wrap-around.
    logic [DATA_W:0]   sp_ext;
`endif

    regfile_tick_timer #(
        .DATA_W   (DATA_W),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .ptime       (ptime_q),
        .delay_start (bus.delay_start),
        .time_out    (time_val),
        .delay_busy  (bus.delay_busy)
    );

    // State update: stacks first, then the explicit write so it wins on the
    // SP/AS index.
    always_comb begin : next_state
        regs_d     = regs_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        ptime_d    = ptime_q;
        cmp_flag_d = cmp_flag_q;
        sp_cur     = regs_q[SP_IDX];
        as_cur     = regs_q[AS_IDX];
        sp_wr_hit  = bus.wr_en && (bus.wr_addr == SP_ADDR);
        as_wr_hit  = bus.wr_en && (bus.wr_addr == AS_ADDR);
`ifdef REGFILE_STACK_CHECK_EN
        stk_ovf_d  = stk_ovf_q;
        stk_unf_d  = stk_unf_q;
        sp_ext     = {1'b0, sp_cur};
`endif

        // Push and pop together cancel out.
        if (!sp_wr_hit && (bus.sp_push != bus.sp_pop)) begin
            if (bus.sp_push) begin
`ifdef REGFILE_STACK_CHECK_EN
                if (sp_ext < ({1'b0, SP_FLOOR} + {1'b0, SP_STEP})) begin
                    stk_ovf_d = 1'b1;
                end else begin
                    regs_d[SP_IDX] = sp_cur - SP_STEP;
                end
`else
                regs_d[SP_IDX] = sp_cur - SP_STEP;
`endif
            end else begin
`ifdef REGFILE_STACK_CHECK_EN
                if ((sp_ext + {1'b0, SP_STEP}) > {1'b0, SP_TOP}) begin
                    stk_unf_d = 1'b1;
                end else begin
                    regs_d[SP_IDX] = sp_cur + SP_STEP;
                end
`else
                regs_d[SP_IDX] = sp_cur + SP_STEP;
`endif
            end
        end

        if (!as_wr_hit && (bus.as_push != bus.as_pop)) begin
            if (bus.as_push) begin
                regs_d[AS_IDX] = as_cur + 1'b1;
            end else begin
`ifdef REGFILE_STACK_CHECK_EN
                if (as_cur == '0) begin
                    stk_unf_d = 1'b1;
                end else begin
                    regs_d[AS_IDX] = as_cur - 1'b1;
                end
`else
                regs_d[AS_IDX] = as_cur - 1'b1;
`endif
            end
        end

        if (bus.wr_en && (bus.wr_addr != '0)) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end

        if (bus.hilo_we) begin
            hi_d = bus.hi_in;
            lo_d = bus.lo_in;
        end

        if (bus.ptime_we) begin
            ptime_d = bus.wr_data;
        end

        if (bus.cmp_we) begin
            cmp_flag_d = bus.cmp_in;
        end
    end

    // Registered read port; only general-register reads see the write bypass.
    always_comb begin : read_path
        rd_data0_d = '0;
        rd_data1_d = '0;
        byp0       = bus.wr_en && (bus.wr_addr == bus.rd_addr0) && (bus.rd_addr0 != '0);
        byp1       = bus.wr_en && (bus.wr_addr == bus.rd_addr1) && (bus.rd_addr1 != '0);

        case (bus.rd_sel)
            RD_REG: begin
                rd_data0_d = byp0 ? bus.wr_data : regs_q[bus.rd_addr0];
                rd_data1_d = byp1 ? bus.wr_data : regs_q[bus.rd_addr1];
            end
            RD_HI:    rd_data0_d = hi_q;
            RD_LO:    rd_data0_d = lo_q;
            RD_TIME:  rd_data0_d = time_val;
            RD_PTIME: rd_data0_d = ptime_q;
            default:  ;
        endcase
    end

    // NOTE: the register array is reset on purpose: SP must come up at SP_TOP
    // and every other register at zero, so this maps to flops, not a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_TOP : '0;
            end
            hi_q       <= '0;
            lo_q       <= '0;
            ptime_q    <= '0;
            rd_data0_q <= '0;
            rd_data1_q <= '0;
            cmp_flag_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            ptime_q    <= ptime_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
            cmp_flag_q <= cmp_flag_d;
        end
    end

`ifdef REGFILE_STACK_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_ovf_q <= 1'b0;
            stk_unf_q <= 1'b0;
        end else begin
            stk_ovf_q <= stk_ovf_d;
            stk_unf_q <= stk_unf_d;
        end
    end

    assign bus.stk_ovf = stk_ovf_q;
    assign bus.stk_unf = stk_unf_q;
`else
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
`endif

    assign bus.rd_data0 = rd_data0_q;
    assign bus.rd_data1 = rd_data1_q;
    assign bus.cmp_flag = cmp_flag_q;
    assign bus.sp_out   = regs_q[SP_IDX];
    assign bus.as_out   = regs_q[AS_IDX];
    assign bus.time_out = time_val;

endmodule : regfile_timer_unit

// File: tb/tb_regfile_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_regfile_timer_unit
// Self-checking bench for regfile_timer_unit (DATA_W=32, REG_COUNT=32,
// PRESCALE=4). Read-port expectations are queued when a read is driven and
// compared one cycle later when the registered data appears. Stack-check
// expectations follow REGFILE_STACK_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_regfile_timer_unit;
    import regfile_pkg::*;

    localparam int DW       = 32;
    localparam int RC       = 32;
    localparam int AW       = 5;
    localparam int PRESCALE = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regfile_timer_unit_if #(.DATA_W(DW), .AW(AW)) bus ();

    regfile_timer_unit #(
        .DATA_W    (DW),
        .REG_COUNT (RC),
        .SP_STEP   (32'd4),
        .SP_TOP    (32'h400),
        .SP_FLOOR  (32'h0),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          chk;
        string       tag;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rd_sel      = RD_NONE;
        bus.rd_addr0    = '0;
        bus.rd_addr1    = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.hilo_we     = 1'b0;
        bus.hi_in       = '0;
        bus.lo_in       = '0;
        bus.ptime_we    = 1'b0;
        bus.cmp_we      = 1'b0;
        bus.cmp_in      = 1'b0;
        bus.sp_push     = 1'b0;
        bus.sp_pop      = 1'b0;
        bus.as_push     = 1'b0;
        bus.as_pop      = 1'b0;
        bus.delay_start = 1'b0;
    endtask

    // Queue the read result expected from this cycle's inputs, clock once,
    // then pop and compare against the registered read data.
    task automatic cycle(input bit chk, input string tag,
                         input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        rd_exp_t e;
        e.chk = chk;
        e.tag = tag;
        e.d0  = e0;
        e.d1  = e1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.chk) begin
            check({e.tag, "_d0"}, bus.rd_data0, e.d0);
            check({e.tag, "_d1"}, bus.rd_data1, e.d1);
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("async_rst_sp", bus.sp_out, 32'h400);
        check("async_rst_busy", bus.delay_busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        idle_inputs();
        #23;
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        check("rst_sp", bus.sp_out, 32'h400);
        check("rst_as", bus.as_out, 32'h0);
        check("rst_busy", bus.delay_busy, 1'b0);
        check("rst_time", bus.time_out, 32'h0);
        check("rst_cmp", bus.cmp_flag, 1'b0);
        check("rst_rd0", bus.rd_data0, 32'h0);
        check("rst_ovf", bus.stk_ovf, 1'b0);
        check("rst_unf", bus.stk_unf, 1'b0);

        // Read SP through the register port
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd31;
        cycle(1, "rd_sp_reset", 32'h400, 32'h0);

        // Write with same-cycle bypass on port 1
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEAD;
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd0; bus.rd_addr1 = 5'd5;
        cycle(1, "bypass", 32'h0, 32'hDEAD);

        // Writes to register 0 are dropped and never bypassed
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd0; bus.rd_addr1 = 5'd5;
        cycle(1, "wr_zero", 32'h0, 32'hDEAD);
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd5; bus.rd_addr1 = 5'd0;
        cycle(1, "readback", 32'hDEAD, 32'h0);

        // HI/LO load alongside a general write; HI read in the load cycle is old
        bus.hilo_we = 1'b1; bus.hi_in = 32'd1; bus.lo_in = 32'd2;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
        bus.rd_sel = RD_HI;
        cycle(1, "hi_old", 32'h0, 32'h0);
        bus.rd_sel = RD_HI; bus.rd_addr1 = 5'd5;
        cycle(1, "hi_rd", 32'd1, 32'h0);
        bus.rd_sel = RD_LO;
        cycle(1, "lo_rd", 32'd2, 32'h0);
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd7; bus.rd_addr1 = 5'd5;
        cycle(1, "reg7_rd", 32'h77, 32'hDEAD);

        // NONE and unused codes read as zero
        bus.rd_sel = RD_NONE; bus.rd_addr0 = 5'd5; bus.rd_addr1 = 5'd7;
        cycle(1, "sel_none", 32'h0, 32'h0);
        bus.rd_sel = 3'd6; bus.rd_addr0 = 5'd5; bus.rd_addr1 = 5'd7;
        cycle(1, "sel_6", 32'h0, 32'h0);
        bus.rd_sel = 3'd7; bus.rd_addr0 = 5'd5; bus.rd_addr1 = 5'd7;
        cycle(1, "sel_7", 32'h0, 32'h0);

        // Compare flag
        bus.cmp_we = 1'b1; bus.cmp_in = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("cmp_set", bus.cmp_flag, 1'b1);
        bus.cmp_in = 1'b0;
        cycle(0, "", 32'h0, 32'h0);
        check("cmp_hold", bus.cmp_flag, 1'b1);
        bus.cmp_we = 1'b1; bus.cmp_in = 1'b0;
        cycle(0, "", 32'h0, 32'h0);
        check("cmp_clr", bus.cmp_flag, 1'b0);

        // Stack boundaries: pop at the empty-stack value, no bypass of stack ops
        bus.sp_pop = 1'b1; bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd31;
        cycle(1, "pop_nobyp", 32'h400, 32'h0);
`ifdef REGFILE_STACK_CHECK_EN
        check("pop_top_sp", bus.sp_out, 32'h400);
        check("pop_top_unf", bus.stk_unf, 1'b1);
`else
        check("pop_top_sp", bus.sp_out, 32'h404);
        check("pop_top_unf", bus.stk_unf, 1'b0);
`endif
        bus.as_pop = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
`ifdef REGFILE_STACK_CHECK_EN
        check("as_pop_zero", bus.as_out, 32'h0);
`else
        check("as_pop_zero", bus.as_out, 32'hFFFF_FFFF);
`endif
        bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'h4;
        cycle(0, "", 32'h0, 32'h0);
        bus.sp_push = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("push_to_floor", bus.sp_out, 32'h0);
        check("push_to_floor_ovf", bus.stk_ovf, 1'b0);
        bus.sp_push = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
`ifdef REGFILE_STACK_CHECK_EN
        check("push_below_floor", bus.sp_out, 32'h0);
        check("push_below_ovf", bus.stk_ovf, 1'b1);
`else
        check("push_below_floor", bus.sp_out, 32'hFFFF_FFFC);
        check("push_below_ovf", bus.stk_ovf, 1'b0);
`endif

        // Stack arithmetic from a fresh reset
        do_reset();
        check("rerst_ovf", bus.stk_ovf, 1'b0);
        check("rerst_unf", bus.stk_unf, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.sp_push = 1'b1;
            cycle(0, "", 32'h0, 32'h0);
        end
        bus.sp_pop = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("sp_3push_1pop", bus.sp_out, 32'h3F8);
        bus.sp_push = 1'b1; bus.sp_pop = 1'b1;
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd31;
        cycle(1, "sp_rd", 32'h3F8, 32'h0);
        check("sp_push_pop", bus.sp_out, 32'h3F8);
        bus.as_push = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        bus.as_push = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        bus.as_push = 1'b1; bus.as_pop = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("as_push_pop", bus.as_out, 32'd2);
        bus.as_pop = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("as_pop", bus.as_out, 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 32'h200; bus.sp_push = 1'b1;
        bus.rd_sel = RD_REG; bus.rd_addr0 = 5'd31; bus.rd_addr1 = 5'd30;
        cycle(1, "sp_wr_byp", 32'h200, 32'd1);
        check("sp_wr_wins", bus.sp_out, 32'h200);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd30; bus.wr_data = 32'h10; bus.as_pop = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("as_wr_wins", bus.as_out, 32'h10);

        // Timer and delay
        do_reset();
        // PTIME load and delay_start together: the old PTIME (0) is used
        bus.ptime_we = 1'b1; bus.wr_data = 32'd3; bus.delay_start = 1'b1;
        cycle(0, "", 32'h0, 32'h0);
        check("start_ptime0_busy", bus.delay_busy, 1'b0);
        bus.rd_sel = RD_PTIME;
        cycle(1, "ptime_rd", 32'd3, 32'h0);
        n = 0;
        while (bus.time_out != 32'd2 && n < 50) begin
            n++;
            cycle(0, "", 32'h0, 32'h0);
        end
        check("wait_time2", bus.time_out, 32'd2);
        // First cycle of TIME=2: arm the delay and read TIME
        bus.delay_start = 1'b1; bus.rd_sel = RD_TIME;
        cycle(1, "time_rd", 32'd2, 32'h0);
        n = 0;
        while (bus.delay_busy === 1'b1 && n < 40) begin
            n++;
            cycle(0, "", 32'h0, 32'h0);
        end
        check("busy_cycles", n, 12);
        check("busy_end_time", bus.time_out, 32'd5);
        cycle(0, "", 32'h0, 32'h0);
        check("busy_stays_low", bus.delay_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_regfile_timer_unit

// File: doc/regfile_timer_unit.md
Name: regfile_timer_unit

Overview:
- Parametrised next-generation register bank for the simple microprocessor datapath.
- Contains:
  - a DATA_W x REG_COUNT general register file with a hardwired zero register;
  - a HI/LO mul/div result pair;
  - hardware stack-pointer (SP) and auxiliary-stack (AS) counters;
  - a compare flag;
  - a prescaled free-running timer with a programmable delay deadline.
- Sits between decode and execute; all state updates on a single clock edge.

Parameters:
- DATA_W, 32, data/register width in bits.
- REG_COUNT, 32, number of general registers (power of 2, >=4); AW = clog2(REG_COUNT).
- SP_STEP, 4, byte step applied to SP per push/pop.
- SP_TOP, 'h400, SP reset value; also the empty-stack value.
- SP_FLOOR, 'h0, lowest legal SP value (used only by the optional feature).
- PRESCALE, 50000, clk cycles per timer tick (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- rd_sel  in  3  read source: 0 NONE, 1 REG, 2 HI, 3 LO, 4 TIME, 5 PTIME.
- rd_addr0, rd_addr1  in  AW  read register indices.
- rd_data0, rd_data1  out  DATA_W  registered read data.
- wr_en  in  1  general register write strobe.
- wr_addr  in  AW  write index.
- wr_data  in  DATA_W  write data.
- hilo_we  in  1  load HI/LO.
- hi_in, lo_in  in  DATA_W  HI/LO load values.
- ptime_we  in  1  load PTIME from wr_data.
- cmp_we  in  1  latch cmp_in into the compare flag.
- cmp_in  in  1  comparator result.
- cmp_flag  out  1  compare flag.
- sp_push, sp_pop  in  1  SP stack operations.
- as_push, as_pop  in  1  AS stack operations.
- sp_out, as_out  out  DATA_W  current SP and AS values.
- delay_start  in  1  arm delay: deadline = TIME + PTIME.
- delay_busy  out  1  high until the deadline is reached.
- time_out  out  DATA_W  current TIME.
- stk_ovf, stk_unf  out  1  sticky stack error flags (optional feature).

Behaviour:
- Reset values (reset low, asynchronous):
  - all registers, HI, LO, TIME, PTIME, the prescaler, AS, rd_data0/1 and cmp_flag = 0;
  - delay_busy = 0;
  - SP = SP_TOP;
  - stk_ovf = stk_unf = 0.
- Reset asserted mid-delay or mid-stack-operation aborts the operation; the state above takes effect immediately.
- Register 0 always reads 0; writes to index 0 are dropped.
- Read path, latency 1 cycle:
  - REG: rd_data0 = reg[rd_addr0], rd_data1 = reg[rd_addr1].
  - HI, LO, TIME, PTIME: value goes on rd_data0; rd_data1 = 0.
  - NONE and codes 6-7: both outputs = 0.
- Write-through bypass: if wr_en and wr_addr == rd_addrN (and nonzero) in the same cycle, rd_dataN returns wr_data.
  - Bypass does not apply to stack or HI/LO updates.
- SP lives in reg[REG_COUNT-1]; AS lives in reg[REG_COUNT-2]; sp_out and as_out show these registers directly.
- SP operations:
  - push: SP -= SP_STEP;
  - pop: SP += SP_STEP.
- AS operations:
  - push: AS += 1;
  - pop: AS -= 1.
- Push and pop asserted together on the same counter: no change.
- wr_en targeting the SP or AS index in the same cycle as a push/pop on that counter: the explicit write wins and the stack operation is discarded.
- Arithmetic is modulo 2^DATA_W; wrap-around is legal when the optional feature is off.
- hilo_we loads HI = hi_in and LO = lo_in. It is independent of wr_en; both may fire in the same cycle.
- Timer:
  - the prescaler counts 0..PRESCALE-1;
  - at terminal count it returns to 0 and TIME += 1 (wraps).
- Delay:
  - delay_start with PTIME != 0: deadline = TIME + PTIME and delay_busy = 1 from the next cycle.
  - delay_busy clears on the first cycle where TIME == deadline. This equality test is wrap-safe.
  - delay_start with PTIME == 0: delay_busy stays 0.
  - delay_start while busy re-arms the deadline from the current TIME.
  - ptime_we in the same cycle as delay_start: the old PTIME is used.

Optional Feature:
- Macro: REGFILE_STACK_CHECK_EN.
- Defined:
  - an SP push is suppressed when SP - SP_STEP < SP_FLOOR, and sets stk_ovf;
  - an SP pop is suppressed when SP + SP_STEP > SP_TOP, and sets stk_unf;
  - an AS pop at 0 is suppressed and sets stk_unf;
  - flags are sticky until reset.
- Undefined: no checks, counters wrap, stk_ovf = stk_unf = 0 constant.

Decomposition:
- Shared package regfile_pkg:
  - rd_sel encoding constants (RD_NONE, RD_REG, RD_HI, RD_LO, RD_TIME, RD_PTIME);
  - SP/AS index localparams.
- One sub-module, regfile_tick_timer:
  - contains the prescaler, TIME, the deadline register and delay_busy;
  - inputs: ptime value and delay_start.

Test Plan:
- Reset then rd_sel=REG, rd_addr0=31 -> rd_data0 = 'h400 after 1 cycle; delay_busy=0; time_out=0.
- wr_en, wr_addr=5, wr_data='hDEAD with rd_addr1=5 in the same cycle -> rd_data1='hDEAD next cycle (bypass); wr_addr=0 -> reg0 still reads 0.
- Three sp_push then one sp_pop -> sp_out='h3F8; as_push+as_pop together -> as_out unchanged; wr_en to index 31 plus sp_push -> SP = wr_data.
- With PRESCALE=4: ptime_we with 3, then delay_start at TIME=2 -> delay_busy high for exactly 12 clk cycles, then low at TIME=5.
- hilo_we hi_in=1, lo_in=2; rd_sel=HI -> rd_data0=1; rd_sel=LO -> rd_data0=2; cmp_we with cmp_in=1 -> cmp_flag=1.
- REGFILE_STACK_CHECK_EN defined: sp_pop at reset -> SP stays 'h400 and stk_unf=1; undefined: SP becomes 'h404 and stk_unf=0.
